// File: rtl/red_and_pkg.sv
// Shared types and sizing helpers for the streaming AND-reduction block.
package red_and_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // floor(log2(v)) for v >= 1; returns 0 for v <= 1.
  function automatic int log2floor(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if (v >= (1 << i)) r = i;
    end
    return r;
  endfunction

  // Width of the beat counter / zero-beat index for a given frame limit.
  function automatic int cnt_width(input int max_beats);
    int w;
    w = log2floor(max_beats - 1) + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/red_and_stream_red_and.sv
// Combinational AND-reduction of one beat word.
module RedAnd #(
  parameter int width = 8
) (
  input  logic [width-1:0] A,
  output logic             Z
);

  assign Z = &A;

endmodule

// File: rtl/red_and_stream.sv
// Streaming AND-reduction: folds a frame of beats into one registered result
// (frame AND, first zero beat, beat count, overflow) behind a valid/ready pair.
module red_and_stream
  import red_and_pkg::*;
#(
  parameter  int width    = 8,
  parameter  int maxBeats = 16,
  localparam int cw       = cnt_width(maxBeats)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [width-1:0] A,
  input  logic             InValid,
  input  logic             InLast,
  output logic             InReady,
  output logic             Z,
  output logic [cw-1:0]    ZeroBeat,
  output logic [cw-1:0]    Beats,
  output logic             Ovf,
  output logic             OutValid,
  input  logic             OutReady
);

  typedef struct packed {
    logic          z;
    logic [cw-1:0] zero_beat;
    logic [cw-1:0] beats;
    logic          ovf;
  } result_t;

  localparam logic [cw-1:0] LAST_CNT = cw'(maxBeats - 1);

  state_e        state_q, state_n;
  logic          acc_q, acc_n;
  logic [cw-1:0] cnt_q, cnt_n;
  logic [cw-1:0] zidx_q, zidx_n;
  logic          zseen_q, zseen_n;
  result_t       res_p1, res_n;
  logic          vld_p1, vld_n;

  logic          beat_and;
  logic          accept;
  logic          at_limit;
  logic          acc_m;
  logic [cw-1:0] zidx_m;

  RedAnd #(.width(width)) u_red_and (
    .A (A),
    .Z (beat_and)
  );

  assign InReady  = !(vld_p1 && !OutReady);
  assign accept   = InValid && InReady;
  assign at_limit = (cnt_q == LAST_CNT);

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    zidx_n  = zidx_q;
    zseen_n = zseen_q;
    res_n   = res_p1;
    vld_n   = vld_p1 && !OutReady;
    acc_m   = acc_q & beat_and;
    zidx_m  = (!zseen_q && !beat_and) ? cnt_q : zidx_q;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (InLast) begin
            // A lone beat can only fail at index 0, so ZeroBeat is 0 either way.
            res_n.z         = beat_and;
            res_n.zero_beat = '0;
            res_n.beats     = '0;
            res_n.ovf       = 1'b0;
            vld_n           = 1'b1;
          end else begin
            acc_n   = beat_and;
            cnt_n   = cw'(1);
            zseen_n = !beat_and;
            zidx_n  = '0;
            state_n = ACC;
          end
        end
        ACC: begin
          if (InLast || at_limit) begin
            res_n.z         = acc_m;
            res_n.zero_beat = acc_m ? '0 : zidx_m;
            res_n.beats     = cnt_q;
            res_n.ovf       = at_limit && !InLast;
            vld_n           = 1'b1;
            acc_n           = 1'b1;
            cnt_n           = '0;
            zseen_n         = 1'b0;
            zidx_n          = '0;
            state_n         = IDLE;
          end else begin
            acc_n   = acc_m;
            zidx_n  = zidx_m;
            zseen_n = zseen_q | !beat_and;
            cnt_n   = cnt_q + cw'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ---- stage p1: frame state and result register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      zidx_q  <= '0;
      zseen_q <= 1'b0;
      res_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      zidx_q  <= zidx_n;
      zseen_q <= zseen_n;
      res_p1  <= res_n;
      vld_p1  <= vld_n;
    end
  end

  assign Z        = res_p1.z;
  assign ZeroBeat = res_p1.zero_beat;
  assign Beats    = res_p1.beats;
  assign Ovf      = res_p1.ovf;
  assign OutValid = vld_p1;

endmodule
